// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
//   Shared types and helpers for the execute stage: multiply/divide opcodes,
//   the mul/div FSM state, ALU operation codes and opcode classification
//   helpers used by both the stage top and the mul/div unit.
// ----------------------------------------------------------------------------
package ex_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // ALUCode values understood by the ALU.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_SLT  = 6;
  localparam int ALU_SLTU = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Operations that launch a multiply or divide.
  function automatic logic is_md_start(input md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  // Operations that touch HI/LO and therefore must wait for the unit.
  function automatic logic is_hilo_op(input md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                      MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO};
  endfunction

  function automatic logic is_signed_md(input md_op_t op);
    return op inside {MD_MULT, MD_DIV};
  endfunction

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
//   Combinational integer ALU. Shifts move operand B by the low bits of
//   operand A (the stage routes the shift amount onto A).
// Ports
//   alu_code_i  operation select (ex_pkg ALU_* codes)
//   a_i, b_i    operands
//   result_o    result
// ----------------------------------------------------------------------------
module alu
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 5
) (
  input  logic [ALUC_W-1:0] alu_code_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    result_o = '0;
    shamt    = a_i[SH_W-1:0];
    case (alu_code_i)
      ALUC_W'(ALU_ADD):  result_o = a_i + b_i;
      ALUC_W'(ALU_SUB):  result_o = a_i - b_i;
      ALUC_W'(ALU_AND):  result_o = a_i & b_i;
      ALUC_W'(ALU_OR):   result_o = a_i | b_i;
      ALUC_W'(ALU_XOR):  result_o = a_i ^ b_i;
      ALUC_W'(ALU_NOR):  result_o = ~(a_i | b_i);
      ALUC_W'(ALU_SLT):  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALUC_W'(ALU_SLTU): result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      ALUC_W'(ALU_SLL):  result_o = b_i << shamt;
      ALUC_W'(ALU_SRL):  result_o = b_i >> shamt;
      ALUC_W'(ALU_SRA):  result_o = $signed(b_i) >>> shamt;
      ALUC_W'(ALU_LUI):  result_o = {b_i[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
      default:           result_o = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide with architectural HI/LO registers.
//   Operands are converted to magnitudes at launch; one shift-add (multiply)
//   or restoring-subtract (divide) step runs per BUSY cycle, and the signs
//   are re-applied when the last step writes HI/LO.
//   Divide by zero yields LO = all ones, HI = dividend.
//   Optional feature macro EX_FAST_MUL_EN: MULT/MULTU finish in the commit
//   cycle through a single-cycle multiplier; divides stay iterative.
// Ports
//   clk, reset  clock, async active-high reset
//   commit_i    instruction in EX commits this cycle
//   op_i        mul/div opcode of the instruction in EX
//   a_i, b_i    forwarded Rs / Rt
//   hi_o, lo_o  HI / LO registers
//   busy_o      iteration in progress
// ----------------------------------------------------------------------------
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit_i,
  input  md_op_t            op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  md_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q;
  logic              div_zero_q;
  logic              neg_res_q;   // negate product / quotient
  logic              neg_rem_q;   // negate remainder (dividend sign)
  logic [DATA_W-1:0] b_q;         // |multiplicand| or |divisor|
  logic [DATA_W-1:0] acc_hi_q;    // product high half or partial remainder
  logic [DATA_W-1:0] acc_lo_q;    // multiplier bits or dividend/quotient bits
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic              start_iter;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_trial;
  logic [DATA_W-1:0]   div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  always_comb begin
    a_neg = is_signed_md(op_i) && a_i[DATA_W-1];
    b_neg = is_signed_md(op_i) && b_i[DATA_W-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

`ifdef EX_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_prod;
  // Sign-extending to 2*DATA_W makes the low half of an unsigned multiply
  // equal to the signed product, so one multiplier serves MULT and MULTU.
  assign fast_prod  = {{DATA_W{a_neg}}, a_i} * {{DATA_W{b_neg}}, b_i};
  assign start_iter = commit_i && (op_i inside {MD_DIV, MD_DIVU});
`else
  assign start_iter = commit_i && is_md_start(op_i);
`endif

  // One iteration step for whichever operation is in flight.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    div_trial = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_ge    = (div_trial >= {1'b0, b_q});
    // The remainder stays below the divisor, so the true difference fits in
    // DATA_W bits whenever it is taken.
    div_diff  = div_trial[DATA_W-1:0] - b_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_trial[DATA_W-1:0];
      step_lo = {acc_lo_q[DATA_W-2:0], div_ge};
    end else begin
      {step_hi, step_lo} = {mul_sum, acc_lo_q[DATA_W-1:1]};
    end
    prod     = {step_hi, step_lo};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = div_zero_q ? '1 : (neg_res_q ? -step_lo : step_lo);
    rem_fix  = neg_rem_q ? -step_hi : step_hi;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_q        <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_iter) begin
            state_q    <= MD_BUSY;
            cnt_q      <= CNT_W'(DATA_W);
            is_div_q   <= (op_i inside {MD_DIV, MD_DIVU});
            div_zero_q <= (b_i == '0);
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            acc_hi_q   <= '0;
            acc_lo_q   <= a_mag;
            b_q        <= b_mag;
          end else if (commit_i) begin
            case (op_i)
              MD_MTHI: hi_q <= a_i;
              MD_MTLO: lo_q <= a_i;
`ifdef EX_FAST_MUL_EN
              MD_MULT, MD_MULTU: {hi_q, lo_q} <= fast_prod;
`endif
              default: ;
            endcase
          end
        end
        MD_BUSY: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= MD_IDLE;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/ex_muldiv_stage.sv
// ----------------------------------------------------------------------------
// ex_muldiv_stage
//   Execute stage between ID/EX and EX/MEM: operand forwarding (MEM has
//   priority over WB, r0 never forwarded), ALU, and a multi-cycle mul/div
//   unit with HI/LO. Stall_ex freezes IF/ID/EX while a HI/LO instruction
//   sits in EX and the unit is still iterating.
//   Optional feature macro EX_FAST_MUL_EN (see muldiv_unit): single-cycle
//   MULT/MULTU.
// Ports
//   clk, reset                         clock, async active-high reset
//   RegDst_ex                          1: dest=Rd, 0: dest=Rt
//   ALUCode_ex                         ALU operation
//   ALUSrcA_ex / ALUSrcB_ex            select Sa_ex / Imm_ex instead of Rs / Rt
//   MdOp_ex                            mul/div/HI/LO operation
//   Advance_ex                         instruction leaves EX at end of cycle
//   Imm_ex, Sa_ex                      pre-extended immediate / shift amount
//   RsAddr_ex, RtAddr_ex, RdAddr_ex    register addresses
//   RsData_ex, RtData_ex               register-file operands
//   ALUResult_mem, RegWriteAddr_mem, RegWrite_mem   MEM forwarding source
//   RegWriteData_wb, RegWriteAddr_wb, RegWrite_wb   WB forwarding source
//   RegWriteAddr_ex                    destination address
//   ALUResult_ex                       ALU result, or HI/LO for MFHI/MFLO
//   MemWriteData_ex                    forwarded Rt
//   Stall_ex                           hold IF/ID/EX this cycle
//   MdBusy                             mul/div iteration in progress
// ----------------------------------------------------------------------------
module ex_muldiv_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegDst_ex,
  input  logic [ALUC_W-1:0] ALUCode_ex,
  input  logic              ALUSrcA_ex,
  input  logic              ALUSrcB_ex,
  input  md_op_t            MdOp_ex,
  input  logic              Advance_ex,
  input  logic [DATA_W-1:0] Imm_ex,
  input  logic [DATA_W-1:0] Sa_ex,
  input  logic [REG_AW-1:0] RsAddr_ex,
  input  logic [REG_AW-1:0] RtAddr_ex,
  input  logic [REG_AW-1:0] RdAddr_ex,
  input  logic [DATA_W-1:0] RsData_ex,
  input  logic [DATA_W-1:0] RtData_ex,
  input  logic [DATA_W-1:0] ALUResult_mem,
  input  logic [DATA_W-1:0] RegWriteData_wb,
  input  logic [REG_AW-1:0] RegWriteAddr_mem,
  input  logic [REG_AW-1:0] RegWriteAddr_wb,
  input  logic              RegWrite_mem,
  input  logic              RegWrite_wb,
  output logic [REG_AW-1:0] RegWriteAddr_ex,
  output logic [DATA_W-1:0] ALUResult_ex,
  output logic [DATA_W-1:0] MemWriteData_ex,
  output logic              Stall_ex,
  output logic              MdBusy
);

  logic              mem_valid, wb_valid;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [DATA_W-1:0] hi, lo;
  logic              commit;

  // A writer targeting r0 is never a forwarding source.
  assign mem_valid = RegWrite_mem && (RegWriteAddr_mem != '0);
  assign wb_valid  = RegWrite_wb  && (RegWriteAddr_wb  != '0);

  // MEM holds the younger value, so it wins when both stages match.
  assign fwd_rs = (mem_valid && RegWriteAddr_mem == RsAddr_ex) ? ALUResult_mem   :
                  (wb_valid  && RegWriteAddr_wb  == RsAddr_ex) ? RegWriteData_wb :
                                                                 RsData_ex;
  assign fwd_rt = (mem_valid && RegWriteAddr_mem == RtAddr_ex) ? ALUResult_mem   :
                  (wb_valid  && RegWriteAddr_wb  == RtAddr_ex) ? RegWriteData_wb :
                                                                 RtData_ex;

  assign alu_a = ALUSrcA_ex ? Sa_ex  : fwd_rs;
  assign alu_b = ALUSrcB_ex ? Imm_ex : fwd_rt;

  alu #(
    .DATA_W (DATA_W),
    .ALUC_W (ALUC_W)
  ) u_alu (
    .alu_code_i (ALUCode_ex),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .result_o   (alu_result)
  );

  // Only HI/LO instructions wait for the unit; everything else flows past a
  // background multiply or divide.
  assign Stall_ex = MdBusy && is_hilo_op(MdOp_ex);
  assign commit   = Advance_ex && !Stall_ex;

  muldiv_unit #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .commit_i (commit),
    .op_i     (MdOp_ex),
    .a_i      (fwd_rs),
    .b_i      (fwd_rt),
    .hi_o     (hi),
    .lo_o     (lo),
    .busy_o   (MdBusy)
  );

  assign RegWriteAddr_ex = RegDst_ex ? RdAddr_ex : RtAddr_ex;
  assign MemWriteData_ex = fwd_rt;
  assign ALUResult_ex    = (MdOp_ex == MD_MFHI) ? hi :
                           (MdOp_ex == MD_MFLO) ? lo : alu_result;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
module tb_ex_muldiv_stage;
  import ex_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int ALUC_W = 5;
`ifdef EX_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = DATA_W;
`endif
  localparam int DIV_LAT    = DATA_W;
  localparam int WAIT_LIMIT = 200;

  logic              clk;
  logic              reset;
  logic              RegDst_ex;
  logic [ALUC_W-1:0] ALUCode_ex;
  logic              ALUSrcA_ex, ALUSrcB_ex;
  md_op_t            MdOp_ex;
  logic              Advance_ex;
  logic [DATA_W-1:0] Imm_ex, Sa_ex;
  logic [REG_AW-1:0] RsAddr_ex, RtAddr_ex, RdAddr_ex;
  logic [DATA_W-1:0] RsData_ex, RtData_ex;
  logic [DATA_W-1:0] ALUResult_mem, RegWriteData_wb;
  logic [REG_AW-1:0] RegWriteAddr_mem, RegWriteAddr_wb;
  logic              RegWrite_mem, RegWrite_wb;
  logic [REG_AW-1:0] RegWriteAddr_ex;
  logic [DATA_W-1:0] ALUResult_ex, MemWriteData_ex;
  logic              Stall_ex, MdBusy;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  ex_muldiv_stage #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .ALUC_W (ALUC_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .RegDst_ex        (RegDst_ex),
    .ALUCode_ex       (ALUCode_ex),
    .ALUSrcA_ex       (ALUSrcA_ex),
    .ALUSrcB_ex       (ALUSrcB_ex),
    .MdOp_ex          (MdOp_ex),
    .Advance_ex       (Advance_ex),
    .Imm_ex           (Imm_ex),
    .Sa_ex            (Sa_ex),
    .RsAddr_ex        (RsAddr_ex),
    .RtAddr_ex        (RtAddr_ex),
    .RdAddr_ex        (RdAddr_ex),
    .RsData_ex        (RsData_ex),
    .RtData_ex        (RtData_ex),
    .ALUResult_mem    (ALUResult_mem),
    .RegWriteData_wb  (RegWriteData_wb),
    .RegWriteAddr_mem (RegWriteAddr_mem),
    .RegWriteAddr_wb  (RegWriteAddr_wb),
    .RegWrite_mem     (RegWrite_mem),
    .RegWrite_wb      (RegWrite_wb),
    .RegWriteAddr_ex  (RegWriteAddr_ex),
    .ALUResult_ex     (ALUResult_ex),
    .MemWriteData_ex  (MemWriteData_ex),
    .Stall_ex         (Stall_ex),
    .MdBusy           (MdBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference {HI, LO} for a mul/div, computed with wide native arithmetic.
  function automatic logic [63:0] md_model(input md_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    md_model = '0;
    case (op)
      MD_MULT: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        md_model = sa * sb;
      end
      MD_MULTU: md_model = {32'b0, a} * {32'b0, b};
      MD_DIVU:  md_model = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MD_DIV: begin
        qa = a;
        qb = b;
        md_model = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(qa % qb), 32'(qa / qb)};
      end
      default: md_model = '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_defaults();
    RegDst_ex        = 1'b1;
    ALUCode_ex       = ALUC_W'(ALU_ADD);
    ALUSrcA_ex       = 1'b0;
    ALUSrcB_ex       = 1'b0;
    MdOp_ex          = MD_NONE;
    Advance_ex       = 1'b1;
    Imm_ex           = '0;
    Sa_ex            = '0;
    RsAddr_ex        = 5'd1;
    RtAddr_ex        = 5'd2;
    RdAddr_ex        = 5'd4;
    RsData_ex        = '0;
    RtData_ex        = '0;
    ALUResult_mem    = '0;
    RegWriteData_wb  = '0;
    RegWriteAddr_mem = '0;
    RegWriteAddr_wb  = '0;
    RegWrite_mem     = 1'b0;
    RegWrite_wb      = 1'b0;
  endtask

  // Present a mul/div for one committing cycle.
  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    MdOp_ex    = op;
    RsData_ex  = a;
    RtData_ex  = b;
    Advance_ex = 1'b1;
    tick();
    MdOp_ex = MD_NONE;
  endtask

  // Put MFHI/MFLO in EX; expected value goes on the scoreboard now and is
  // popped when the instruction is no longer stalled.
  task automatic read_hilo(input md_op_t op, input logic [31:0] exp_val,
                           input int exp_stalls, input string name);
    int stalls;
    logic [31:0] e;
    stalls = 0;
    exp_q.push_back(exp_val);
    MdOp_ex    = op;
    Advance_ex = 1'b1;
    forever begin
      @(negedge clk);
      if (!Stall_ex) break;
      stalls++;
      if (stalls > WAIT_LIMIT) break;
      tick();
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (stalls !== exp_stalls) begin
      n_err++;
      $display("FAIL %s stall cycles: got %0d, want %0d", name, stalls, exp_stalls);
    end
    n_cmp++;
    if (ALUResult_ex !== e) begin
      n_err++;
      $display("FAIL %s value: got %h, want %h", name, ALUResult_ex, e);
    end
    tick();
    MdOp_ex = MD_NONE;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    MdOp_ex = MD_MFHI;
    #1;
    n_cmp++;
    if (MdBusy !== 1'b0) begin n_err++; $display("FAIL reset MdBusy: got %b, want 0", MdBusy); end
    n_cmp++;
    if (Stall_ex !== 1'b0) begin n_err++; $display("FAIL reset Stall_ex: got %b, want 0", Stall_ex); end
    n_cmp++;
    if (ALUResult_ex !== 32'h0) begin n_err++; $display("FAIL reset HI: got %h, want 0", ALUResult_ex); end
    MdOp_ex = MD_MFLO;
    #1;
    n_cmp++;
    if (ALUResult_ex !== 32'h0) begin n_err++; $display("FAIL reset LO: got %h, want 0", ALUResult_ex); end
    MdOp_ex = MD_NONE;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_forwarding();
    ALUCode_ex = ALUC_W'(ALU_ADD);
    ALUSrcA_ex = 1'b0;
    ALUSrcB_ex = 1'b1;
    Imm_ex     = '0;
    RsAddr_ex  = 5'd3;
    RsData_ex  = 32'h1111_1111;
    RegWriteAddr_mem = 5'd3; ALUResult_mem   = 32'hAAAA_0000; RegWrite_mem = 1'b1;
    RegWriteAddr_wb  = 5'd3; RegWriteData_wb = 32'h0000_5555; RegWrite_wb  = 1'b1;
    #1;
    n_cmp++;
    if (ALUResult_ex !== 32'hAAAA_0000) begin n_err++; $display("FAIL fwd mem priority: got %h, want aaaa0000", ALUResult_ex); end
    RegWrite_mem = 1'b0;
    #1;
    n_cmp++;
    if (ALUResult_ex !== 32'h0000_5555) begin n_err++; $display("FAIL fwd wb: got %h, want 00005555", ALUResult_ex); end
    RegWrite_wb = 1'b0;
    #1;
    n_cmp++;
    if (ALUResult_ex !== 32'h1111_1111) begin n_err++; $display("FAIL fwd regfile: got %h, want 11111111", ALUResult_ex); end
    // r0 is never forwarded even when both stages claim to write it.
    RsAddr_ex = 5'd0; RsData_ex = 32'h0BAD_F00D;
    RegWriteAddr_mem = 5'd0; RegWrite_mem = 1'b1;
    RegWriteAddr_wb  = 5'd0; RegWrite_wb  = 1'b1;
    #1;
    n_cmp++;
    if (ALUResult_ex !== 32'h0BAD_F00D) begin n_err++; $display("FAIL fwd r0: got %h, want 0badf00d", ALUResult_ex); end
    // Rt path: WB match only, MEM writes another register.
    RtAddr_ex = 5'd7; RtData_ex = 32'h77;
    RegWriteAddr_mem = 5'd3; RegWrite_mem = 1'b1; ALUResult_mem = 32'hDEAD_0001;
    RegWriteAddr_wb  = 5'd7; RegWrite_wb  = 1'b1; RegWriteData_wb = 32'h0000_CAFE;
    #1;
    n_cmp++;
    if (MemWriteData_ex !== 32'h0000_CAFE) begin n_err++; $display("FAIL fwd rt wb: got %h, want 0000cafe", MemWriteData_ex); end
    RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
    // Shift by Sa: ALU_A from Sa_ex, ALU_B from Rt.
    ALUCode_ex = ALUC_W'(ALU_SLL); ALUSrcA_ex = 1'b1; ALUSrcB_ex = 1'b0;
    Sa_ex = 32'd4; RtData_ex = 32'h1;
    #1;
    n_cmp++;
    if (ALUResult_ex !== 32'h10) begin n_err++; $display("FAIL sll by sa: got %h, want 00000010", ALUResult_ex); end
    RegDst_ex = 1'b1; RdAddr_ex = 5'd9;
    #1;
    n_cmp++;
    if (RegWriteAddr_ex !== 5'd9) begin n_err++; $display("FAIL dest rd: got %0d, want 9", RegWriteAddr_ex); end
    RegDst_ex = 1'b0;
    #1;
    n_cmp++;
    if (RegWriteAddr_ex !== 5'd7) begin n_err++; $display("FAIL dest rt: got %0d, want 7", RegWriteAddr_ex); end
    drive_defaults();
    tick();
  endtask

  task automatic test_multu_stall();
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2);
    read_hilo(MD_MFLO, 32'hFFFF_FFFE, MUL_LAT, "multu lo");
    read_hilo(MD_MFHI, 32'h0000_0001, 0, "multu hi");
  endtask

  task automatic test_div();
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h2);
    read_hilo(MD_MFLO, 32'hFFFF_FFFD, DIV_LAT, "div -7/2 lo");
    read_hilo(MD_MFHI, 32'hFFFF_FFFF, 0, "div -7/2 hi");
    issue(MD_DIVU, 32'h7, 32'h2);
    read_hilo(MD_MFLO, 32'h3, DIV_LAT, "divu 7/2 lo");
    read_hilo(MD_MFHI, 32'h1, 0, "divu 7/2 hi");
  endtask

  task automatic test_div_zero();
    issue(MD_DIV, 32'h5, 32'h0);
    // Independent ADD right behind the divide must flow without a stall.
    ALUCode_ex = ALUC_W'(ALU_ADD); ALUSrcA_ex = 1'b0; ALUSrcB_ex = 1'b0;
    RsData_ex = 32'd10; RtData_ex = 32'd20;
    @(negedge clk);
    n_cmp++;
    if (Stall_ex !== 1'b0) begin n_err++; $display("FAIL add behind div stall: got %b, want 0", Stall_ex); end
    n_cmp++;
    if (MdBusy !== 1'b1) begin n_err++; $display("FAIL div busy: got %b, want 1", MdBusy); end
    n_cmp++;
    if (ALUResult_ex !== 32'd30) begin n_err++; $display("FAIL add behind div: got %h, want 0000001e", ALUResult_ex); end
    tick();
    read_hilo(MD_MFLO, 32'hFFFF_FFFF, DIV_LAT - 1, "div 5/0 lo");
    read_hilo(MD_MFHI, 32'h5, 0, "div 5/0 hi");
    issue(MD_DIV, 32'hFFFF_FFFB, 32'h0);
    read_hilo(MD_MFLO, 32'hFFFF_FFFF, DIV_LAT, "div -5/0 lo");
    read_hilo(MD_MFHI, 32'hFFFF_FFFB, 0, "div -5/0 hi");
  endtask

  task automatic test_advance_hold();
    int stalls;
    // A MULT held in EX must not start the unit.
    MdOp_ex = MD_MULT; RsData_ex = 32'd3; RtData_ex = 32'hFFFF_FFFC; Advance_ex = 1'b0;
    tick();
    n_cmp++;
    if (MdBusy !== 1'b0) begin n_err++; $display("FAIL mult held busy: got %b, want 0", MdBusy); end
    Advance_ex = 1'b1;
    tick();
    MdOp_ex = MD_MTHI; RsData_ex = 32'h0000_1234; Advance_ex = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (Stall_ex !== (MUL_LAT != 0)) begin
        n_err++;
        $display("FAIL mthi held stall cycle %0d: got %b, want %b", i, Stall_ex, (MUL_LAT != 0));
      end
      tick();
    end
    Advance_ex = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!Stall_ex) break;
      stalls++;
      if (stalls > WAIT_LIMIT) break;
      tick();
    end
    n_cmp++;
    if (stalls !== ((MUL_LAT == 0) ? 0 : MUL_LAT - 3)) begin
      n_err++;
      $display("FAIL mthi stall cycles: got %0d, want %0d", stalls, (MUL_LAT == 0) ? 0 : MUL_LAT - 3);
    end
    tick();
    MdOp_ex = MD_NONE;
    read_hilo(MD_MFHI, 32'h0000_1234, 0, "mthi hi");
    read_hilo(MD_MFLO, 32'hFFFF_FFF4, 0, "mult 3*-4 lo");
  endtask

  task automatic test_reset_mid_busy();
    issue(MD_DIVU, 32'd100, 32'd7);
    MdOp_ex = MD_MFHI;
    repeat (9) tick();
    n_cmp++;
    if (Stall_ex !== 1'b1) begin n_err++; $display("FAIL pre-reset stall: got %b, want 1", Stall_ex); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (MdBusy !== 1'b0) begin n_err++; $display("FAIL mid-busy reset MdBusy: got %b, want 0", MdBusy); end
    n_cmp++;
    if (Stall_ex !== 1'b0) begin n_err++; $display("FAIL mid-busy reset Stall_ex: got %b, want 0", Stall_ex); end
    n_cmp++;
    if (ALUResult_ex !== 32'h0) begin n_err++; $display("FAIL mid-busy reset HI: got %h, want 0", ALUResult_ex); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    read_hilo(MD_MFLO, 32'h0, 0, "post-reset lo");
  endtask

  task automatic test_back_to_back();
    md_op_t ops[4];
    logic [31:0] a, b;
    logic [63:0] e;
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (ops[i % 4] inside {MD_DIV, MD_DIVU}) begin
        b = $urandom_range(1, 1000);
        if ((ops[i % 4] == MD_DIV) && ($urandom_range(0, 1) == 1)) b = -b;
      end
      e = md_model(ops[i % 4], a, b);
      issue(ops[i % 4], a, b);
      read_hilo(MD_MFLO, e[31:0], (ops[i % 4] inside {MD_MULT, MD_MULTU}) ? MUL_LAT : DIV_LAT,
                $sformatf("b2b[%0d] lo", i));
      read_hilo(MD_MFHI, e[63:32], 0, $sformatf("b2b[%0d] hi", i));
    end
  endtask

  initial begin
    drive_defaults();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_multu_stall();
    test_div();
    test_div_zero();
    test_advance_hold();
    test_reset_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
